// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, opcodes and fetch-stage types for the MIPS front end
package mips_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fetch_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: imem request/response, branch redirect and decode channels of the fetch stage
interface mips_fetch_unit_if;
  import mips_pkg::*;
  logic imem_req_valid;
  logic imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic ins_valid;
  logic ins_ready;
  logic [INSTR_W-1:0] ins_data;
  logic [5:0] ins_opcode;
  logic [ADDR_W-1:0] ins_pc;
  modport master (
    output imem_req_valid, imem_req_addr, ins_valid, ins_data, ins_opcode, ins_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
  );
  modport slave (
    input imem_req_valid, imem_req_addr, ins_valid, ins_data, ins_opcode, ins_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
  );
endinterface

// File: rtl/mips_fetch_unit_fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched {pc, instr}; flush empties it and overrides push/pop
module fetch_queue
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         empty,
  output logic [1:0]   count
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic full, do_push, do_pop;
  assign empty = cnt_q == 2'd0;
  assign full = cnt_q == 2'd2;
  assign do_pop = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d = flush ? 1'b0 : wr_q ^ do_push;
    rd_d = flush ? 1'b0 : rd_q ^ do_pop;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(do_push) - 2'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner issuing one outstanding imem read at a time into a 2-entry decode queue
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  mips_fetch_unit_if.master bus
);
  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic discard_q, discard_d;
  logic redir, req_fire, rsp, push, pop, space, q_empty;
  logic [1:0] q_cnt, cnt_after;
  fetch_entry_t head, rsp_entry;
  assign redir = bus.redirect_valid;
  assign req_fire = state_q == S_REQ && bus.imem_req_ready;
  assign rsp = state_q == S_WAIT && bus.imem_rsp_valid;
  assign push = rsp && !discard_q && !redir;
  assign pop = !q_empty && bus.ins_ready;
  assign cnt_after = q_cnt + 2'(push) - 2'(pop);
  assign space = redir || cnt_after < DEPTH;
  assign rsp_entry = '{pc: req_pc_q, data: bus.imem_rsp_data};
  fetch_queue u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .wdata (rsp_entry),
    .rdata (head),
    .empty (q_empty),
    .count (q_cnt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      discard_q <= discard_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = (redir || q_cnt < DEPTH) ? S_REQ : S_IDLE;
      S_REQ: state_d = req_fire ? S_WAIT : S_REQ;
      S_WAIT: state_d = bus.imem_rsp_valid ? (space ? S_REQ : S_IDLE) : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  // a redirect racing an in-flight request leaves one response to swallow
  always_comb begin
    pc_d = redir ? bus.redirect_pc & ~ADDR_W'(3) : req_fire ? pc_q + ADDR_W'(4) : pc_q;
    req_pc_d = req_fire ? pc_q : req_pc_q;
    discard_d = rsp ? 1'b0 : (redir && (state_q == S_WAIT || req_fire)) ? 1'b1 : discard_q;
  end
  always_comb begin
    bus.imem_req_valid = state_q == S_REQ;
    bus.imem_req_addr = pc_q;
    bus.ins_valid = !q_empty;
    bus.ins_data = q_empty ? '0 : head.data;
    bus.ins_pc = q_empty ? '0 : head.pc;
    bus.ins_opcode = q_empty ? 6'd0 : head.data[INSTR_W-1:INSTR_W-6];
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: scoreboard bench driving the fetch stage from a small instruction-memory model
module tb_mips_fetch_unit;
  import mips_pkg::*;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [5:0]  op;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] addr_q[$];
  int budget = 0;
  logic hold = 1'b0, pend = 1'b0, acc = 1'b0;
  logic [31:0] acc_addr = '0, pend_addr = '0;

  mips_fetch_unit_if bus ();
  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0000_0020;
      32'h4: return 32'h8C00_0000;
      32'h8: return 32'hAC00_0000;
      32'hC: return 32'h1000_0000;
      default: return ~a;
    endcase
  endfunction

  // acceptance and decode handshakes are sampled mid-cycle, where inputs and outputs are settled
  always @(negedge clk) begin
    acc = rst_n && bus.imem_req_valid && bus.imem_req_ready;
    if (acc) begin
      acc_addr = bus.imem_req_addr;
      if (addr_q.size() == 0) check("req_pending", 32'(addr_q.size()), 1);
      else check("req_addr", acc_addr, addr_q.pop_front());
    end
    if (rst_n && bus.ins_valid && bus.ins_ready) begin
      if (exp_q.size() == 0) check("ins_pending", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        check("ins_pc", bus.ins_pc, e.pc);
        check("ins_data", bus.ins_data, e.data);
        check("ins_opcode", 32'(bus.ins_opcode), 32'(e.op));
      end
    end
  end

  // memory: one-cycle latency unless hold parks the response; survives DUT reset on purpose
  always @(posedge clk) begin
    #1;
    if (acc) begin
      pend = 1'b1;
      pend_addr = acc_addr;
      budget--;
    end
    bus.imem_rsp_valid = pend && !hold;
    bus.imem_rsp_data = pend ? mem_word(pend_addr) : '0;
    if (pend && !hold) pend = 1'b0;
    bus.imem_req_ready = budget > 0;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] d, input logic [5:0] op);
    exp_q.push_back('{pc: pc, data: d, op: op});
  endtask

  task automatic push_word(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    push_exp(pc, w, w[31:26]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ins_left"}, 32'(exp_q.size()), 0);
    check({tag, "_req_left"}, 32'(addr_q.size()), 0);
  endtask

  task automatic wait_pend(input string tag);
    int n = 0;
    while (!pend && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(pend), 1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.ins_ready = 1'b0;
    tick(2);
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_ins_valid", 32'(bus.ins_valid), 0);
    check("rst_ins_data", bus.ins_data, 0);
    check("rst_ins_opcode", 32'(bus.ins_opcode), 0);
    check("rst_ins_pc", bus.ins_pc, 0);
    rst_n = 1'b1;
    tick();

    bus.ins_ready = 1'b1;
    push_exp(32'h0, 32'h0000_0020, OP_RTYPE);
    push_exp(32'h4, 32'h8C00_0000, OP_LW);
    push_exp(32'h8, 32'hAC00_0000, OP_SW);
    push_exp(32'hC, 32'h1000_0000, OP_BEQ);
    addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    budget = 4;
    drain("stream");
    check("stream_empty", 32'(bus.ins_valid), 0);
    check("stream_next_addr", bus.imem_req_addr, 32'h10);

    bus.ins_ready = 1'b0;
    for (int a = 32'h10; a <= 32'h1C; a += 4) begin
      push_word(32'(a));
      addr_q.push_back(32'(a));
    end
    budget = 4;
    tick(12);
    check("bp_req_valid", 32'(bus.imem_req_valid), 0);
    check("bp_req_left", 32'(addr_q.size()), 2);
    check("bp_pc_a", bus.ins_pc, 32'h10);
    check("bp_data_a", bus.ins_data, mem_word(32'h10));
    tick(3);
    check("bp_pc_b", bus.ins_pc, 32'h10);
    check("bp_data_b", bus.ins_data, mem_word(32'h10));
    bus.ins_ready = 1'b1;
    drain("bp");

    hold = 1'b1;
    addr_q.push_back(32'h20);
    budget = 1;
    wait_pend("rdw_pend");
    check("rdw_in_wait", 32'(bus.imem_req_valid), 0);
    redirect(32'h100);
    hold = 1'b0;
    push_word(32'h100);
    push_word(32'h104);
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h104);
    budget = 2;
    drain("rdw");

    bus.ins_ready = 1'b0;
    addr_q.push_back(32'h108);
    addr_q.push_back(32'h10C);
    budget = 2;
    n = 0;
    while (!(bus.imem_rsp_valid && bus.ins_valid) && n < 50) begin
      tick();
      n++;
    end
    check("co_rsp_seen", 32'(bus.imem_rsp_valid), 1);
    check("co_head_pc", bus.ins_pc, 32'h108);
    redirect(32'h200);
    check("co_ins_valid", 32'(bus.ins_valid), 0);
    check("co_req_valid", 32'(bus.imem_req_valid), 1);
    check("co_req_addr", bus.imem_req_addr, 32'h200);

    redirect(32'h0000_0106);
    check("mis_req_addr", bus.imem_req_addr, 32'h104);
    redirect(32'hFFFF_FFFC);
    check("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    bus.ins_ready = 1'b1;
    push_word(32'hFFFF_FFFC);
    push_exp(32'h0, 32'h0000_0020, OP_RTYPE);
    addr_q.push_back(32'hFFFF_FFFC);
    addr_q.push_back(32'h0);
    budget = 2;
    drain("wrap");
    check("wrap_next_addr", bus.imem_req_addr, 32'h4);

    bus.ins_ready = 1'b0;
    addr_q.push_back(32'h4);
    budget = 1;
    n = 0;
    while (!bus.ins_valid && n < 50) begin
      tick();
      n++;
    end
    check("ar_pre_valid", 32'(bus.ins_valid), 1);
    hold = 1'b1;
    addr_q.push_back(32'h8);
    budget = 1;
    wait_pend("ar_pend");
    rst_n = 1'b0;
    #1;
    check("ar_ins_valid", 32'(bus.ins_valid), 0);
    check("ar_ins_data", bus.ins_data, 0);
    check("ar_ins_opcode", 32'(bus.ins_opcode), 0);
    check("ar_ins_pc", bus.ins_pc, 0);
    check("ar_req_valid", 32'(bus.imem_req_valid), 0);
    check("ar_req_addr", bus.imem_req_addr, 32'h0);
    tick(2);
    rst_n = 1'b1;
    hold = 1'b0;
    tick(4);
    check("ar_stale_sent", 32'(pend), 0);
    check("ar_late_ignored", 32'(bus.ins_valid), 0);
    check("ar_req_valid2", 32'(bus.imem_req_valid), 1);
    check("ar_first_addr", bus.imem_req_addr, 32'h0);
    bus.ins_ready = 1'b1;
    push_exp(32'h0, 32'h0000_0020, OP_RTYPE);
    addr_q.push_back(32'h0);
    budget = 1;
    drain("ar");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction fetch stage that produces the opcode/instruction stream consumed by control_unit (ins[5:0] = instr[31:26]). Owns the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words in a 2-entry queue. Presents them to decode with a valid/ready handshake. Accepts PC redirects (taken beq) from the execute stage.

Parameters:
ADDR_W, 32, PC / memory address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, instruction queue entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  word-aligned fetch address
imem_rsp_valid  in  1  read data returned (exactly one per accepted request, any latency >=1 cycle)
imem_rsp_data  in  INSTR_W  instruction word
redirect_valid  in  1  branch taken, refetch from redirect_pc
redirect_pc  in  ADDR_W  new PC; bits [1:0] forced to 0
ins_valid  out  1  instruction available to decode
ins_ready  in  1  decode consumes instruction
ins_data  out  INSTR_W  instruction word
ins_opcode  out  6  ins_data[31:26], feeds control_unit
ins_pc  out  ADDR_W  address of ins_data

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, queue empty, state IDLE, imem_req_valid=0, ins_valid=0, ins_data/ins_opcode/ins_pc=0, discard flag=0. Reset mid-transaction drops any outstanding response silently.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when queue occupancy < 2 (space for the returning word).
  - REQ: imem_req_valid=1, imem_req_addr=pc; held stable until accepted. On valid&ready: record req_pc=pc, pc<=pc+4 (wraps modulo 2^ADDR_W), -> WAIT.
  - WAIT: on imem_rsp_valid push {req_pc, data} unless discard flag set; clear discard; -> REQ if space remains after push, else IDLE.
- At most one outstanding request. Best-case throughput: one instruction per 2 cycles with 1-cycle memory.
- Queue: 2-entry FIFO. Head drives ins_*; ins_valid = not empty. Pop on ins_valid&ins_ready. Push and pop in the same cycle are allowed at any occupancy, including full. ins_* are stable while ins_valid&!ins_ready. ins_opcode is 0 when empty.
- Redirect (redirect_valid=1, any state), effective next edge:
  - queue flushed (ins_valid=0 next cycle; a same-cycle pop is ignored)
  - pc<=redirect_pc&~3
  - in WAIT: discard flag set; the pending response is dropped; FSM stays in WAIT
  - in REQ not yet accepted: request withdrawn; imem_req_addr shows the new pc next cycle
  - in REQ accepted same cycle: treated as WAIT with discard=1; pc does not add 4
- Redirect with simultaneous imem_rsp_valid in WAIT: the response is dropped, discard is not left set, next state is REQ.
- Back-to-back redirects: the last one wins; only one discard outstanding is ever needed.

Decomposition:
- Shared package mips_pkg: ADDR_W, INSTR_W, opcode constants OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, fetch FSM state enum.
- One sub-module: fetch_queue (2-entry FIFO, push/pop/flush, full/empty).

Test Plan:
- Reset then streaming: memory returns 0x0000_0020 (R-type), 0x8C00_0000 (lw), 0xAC00_0000 (sw), 0x1000_0000 (beq) at 0,4,8,C with 1-cycle latency, ins_ready=1 -> ins_opcode sequence 000000,100011,101011,000100 with ins_pc 0,4,8,C. imem_req_addr increments by 4.
- Backpressure: ins_ready=0 -> after 2 words, no new imem_req_valid; ins_data held stable. Raise ins_ready -> fetch resumes at pc=8 with no word lost or duplicated.
- Redirect during WAIT: redirect_pc=0x100 while request for 0x8 is outstanding -> the 0x8 response is dropped, next request addr=0x100, first ins_pc=0x100.
- Redirect coincident with imem_rsp_valid and a full queue -> the queue is emptied and the response is discarded. ins_valid=0 next cycle, next request addr=redirect_pc.
- Misaligned redirect 0x0000_0106 -> imem_req_addr=0x104. PC at 0xFFFF_FFFC wraps to 0x0 after fetch.
- Async reset asserted in WAIT -> outputs are 0 immediately. A late imem_rsp_valid after reset release is ignored, and the first request addr=RESET_PC.
